// File: rtl/lab4d_fifo_pkg.sv
// Shared types and register map for the LAB4D Wishbone sample FIFO.
package lab4d_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    ACK  = 2'd2
  } state_e;

  localparam int unsigned MAX_CH = 32;
  localparam int unsigned CH_W   = 5;

  // Register page word indices (byte address bits [9:2])
  localparam logic [7:0] REG_CTRL  = 8'h00;
  localparam logic [7:0] REG_EMPTY = 8'h01;
  localparam logic [7:0] REG_OVF   = 8'h02;
  localparam logic [7:0] REG_UNF   = 8'h03;
  localparam logic [7:0] REG_COUNT = 8'h40;

  localparam int unsigned CTRL_FLUSH = 0;
  localparam int unsigned CTRL_CLR   = 1;

endpackage

// File: rtl/lab4d_wb_sample_fifo_if.sv
// Wishbone slave bus bundle for the sample FIFO; names are from the slave's view.
interface lab4d_wb_sample_fifo_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [15:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;
  logic [31:0] wb_dat_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
  );
endinterface

// File: rtl/lab4d_chan_fifo.sv
// One channel: 16->32 bit packer feeding a simple dual-port RAM FIFO with registered read.
module lab4d_chan_fifo #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  wr_i,
  input  logic [15:0]           dat_i,
  input  logic                  pop_i,
  output logic [31:0]           rd_data_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  empty_o,
  output logic                  ovf_c_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  logic [31:0]           mem_q [DEPTH];
  logic [31:0]           rd_data_q;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  empty_q, empty_d;
  logic [15:0]           half_q, half_d;
  logic                  half_vld_q, half_vld_d;
  logic                  full_c, push_c, accept_c;

  assign full_c   = (count_q == CNT_W'(DEPTH));
  assign push_c   = wr_i & half_vld_q & ~flush_i;
  // A full channel still accepts when a pop frees a slot in the same cycle
  assign accept_c = push_c & (~full_c | pop_i);
  assign ovf_c_o  = push_c & full_c & ~pop_i;

  always_comb begin
    half_d     = half_q;
    half_vld_d = half_vld_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CNT_W'(accept_c) - CNT_W'(pop_i);
    empty_d    = (count_d == '0);
    if (wr_i) begin
      if (half_vld_q) begin
        half_vld_d = 1'b0;
      end else begin
        half_d     = dat_i;
        half_vld_d = 1'b1;
      end
    end
    if (accept_c) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop_i)    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      half_q     <= '0;
      half_vld_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      half_q     <= half_d;
      half_vld_q <= half_vld_d;
    end
  end

  // Read-before-write when full: a same-cycle push/pop hits the same address
  always_ff @(posedge clk_i) begin
    if (accept_c) mem_q[wr_ptr_q] <= {dat_i, half_q};
    if (pop_i)    rd_data_q       <= mem_q[rd_ptr_q];
  end

  assign rd_data_o = rd_data_q;
  assign count_o   = count_q;
  assign empty_o   = empty_q;

endmodule

// File: rtl/lab4d_wb_sample_fifo.sv
// LAB4D multi-channel sample buffer behind a Wishbone slave: FSM, decode, sticky flags, read mux.
module lab4d_wb_sample_fifo
  import lab4d_fifo_pkg::*;
#(
  parameter int unsigned NUM_CH     = 24,
  parameter int unsigned DATA_BITS  = 16,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  lab4d_wb_sample_fifo_if.slave       wb,
  input  logic [NUM_CH*DATA_BITS-1:0] lab_dat_i,
  input  logic [NUM_CH-1:0]           lab_wr_i,
  output logic                        fifo_empty_o
);

  localparam int unsigned L4W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  state_e            state_q, state_d;
  logic              ack_q, ack_d;
  logic [31:0]       dat_q, dat_d;
  logic              we_q, we_d, win_q, win_d, rd_vld_q, rd_vld_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [7:0]        idx_q, idx_d;
  logic [MAX_CH-1:0] ovf_q, ovf_d, unf_q, unf_d;

  logic [MAX_CH-1:0] pop_c, unf_set_c, empty_c, drop_c;
  logic [31:0]       rd_data_c [MAX_CH];
  logic [CNT_W-1:0]  count_c [MAX_CH];
  logic              flush_c, clr_c, sel_ok_c;
  logic [CH_W-1:0]   sel_ch_c;
  logic [31:0]       rdmux_c;
  logic              unused_bits;

  assign sel_ch_c = CH_W'(wb.wb_adr_i[14 -: L4W]);
  assign sel_ok_c = (32'(sel_ch_c) < NUM_CH);

  // Unpopulated slots read as zero and never flag
  for (genvar i = 0; i < MAX_CH; i++) begin : g_ch
    if (i < NUM_CH) begin : g_on
      lab4d_chan_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_chan (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .flush_i   (flush_c),
        .wr_i      (lab_wr_i[i]),
        .dat_i     (lab_dat_i[DATA_BITS*i +: DATA_BITS]),
        .pop_i     (pop_c[i]),
        .rd_data_o (rd_data_c[i]),
        .count_o   (count_c[i]),
        .empty_o   (empty_c[i]),
        .ovf_c_o   (drop_c[i])
      );
    end else begin : g_off
      assign rd_data_c[i] = '0;
      assign count_c[i]   = '0;
      assign empty_c[i]   = 1'b0;
      assign drop_c[i]    = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    ack_d     = 1'b0;
    dat_d     = dat_q;
    we_d      = we_q;
    win_d     = win_q;
    rd_vld_d  = rd_vld_q;
    ch_d      = ch_q;
    idx_d     = idx_q;
    pop_c     = '0;
    unf_set_c = '0;
    flush_c   = 1'b0;
    clr_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (wb.wb_cyc_i && wb.wb_stb_i) begin
          state_d  = READ;
          we_d     = wb.wb_we_i;
          win_d    = ~wb.wb_adr_i[15];
          ch_d     = sel_ch_c;
          idx_d    = wb.wb_adr_i[9:2];
          rd_vld_d = 1'b0;
          if (wb.wb_we_i) begin
            if (wb.wb_adr_i[15] && (wb.wb_adr_i[9:2] == REG_CTRL)) begin
              flush_c = wb.wb_dat_i[CTRL_FLUSH];
              clr_c   = wb.wb_dat_i[CTRL_CLR];
            end
          end else if (!wb.wb_adr_i[15] && sel_ok_c) begin
            if (empty_c[sel_ch_c]) begin
              unf_set_c[sel_ch_c] = 1'b1;
            end else begin
              pop_c[sel_ch_c] = 1'b1;
              rd_vld_d        = 1'b1;
            end
          end
        end
      end
      READ: begin
        state_d = ACK;
        ack_d   = 1'b1;
        dat_d   = rdmux_c;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sticky flags: clear first so a same-cycle event still lands
  always_comb begin
    ovf_d = (clr_c ? '0 : ovf_q) | drop_c;
    unf_d = (clr_c ? '0 : unf_q) | unf_set_c;
  end

  always_comb begin
    rdmux_c = '0;
    if (!we_q) begin
      if (win_q) begin
        if (rd_vld_q) rdmux_c = rd_data_c[ch_q];
      end else begin
        case (idx_q)
          REG_EMPTY: rdmux_c = empty_c;
          REG_OVF:   rdmux_c = ovf_q;
          REG_UNF:   rdmux_c = unf_q;
          default: begin
            if ((idx_q >= REG_COUNT) && (idx_q < (REG_COUNT + 8'(NUM_CH))))
              rdmux_c = 32'(count_c[CH_W'(idx_q - REG_COUNT)]);
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      we_q     <= 1'b0;
      win_q    <= 1'b0;
      rd_vld_q <= 1'b0;
      ch_q     <= '0;
      idx_q    <= '0;
      ovf_q    <= '0;
      unf_q    <= '0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      we_q     <= we_d;
      win_q    <= win_d;
      rd_vld_q <= rd_vld_d;
      ch_q     <= ch_d;
      idx_q    <= idx_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign wb.wb_ack_o  = ack_q;
  assign wb.wb_dat_o  = dat_q;
  assign wb.wb_err_o  = 1'b0;
  assign wb.wb_rty_o  = 1'b0;
  assign fifo_empty_o = &empty_c[NUM_CH-1:0];

  assign unused_bits = ^{wb.wb_sel_i, wb.wb_adr_i, wb.wb_dat_i, pop_c};

endmodule

// File: tb/tb_lab4d_wb_sample_fifo.sv
// Directed bench for the LAB4D Wishbone sample FIFO (NUM_CH=24, DEPTH_LOG2=4).
module tb_lab4d_wb_sample_fifo;

  localparam int unsigned NUM_CH     = 24;
  localparam int unsigned DEPTH_LOG2 = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_CH*16-1:0] lab_dat = '0;
  logic [NUM_CH-1:0]    lab_wr = '0;
  logic                 fifo_empty;
  int                   checks = 0;
  int                   errors = 0;

  lab4d_wb_sample_fifo_if bus ();

  lab4d_wb_sample_fifo #(
    .NUM_CH(NUM_CH), .DATA_BITS(16), .DEPTH_LOG2(DEPTH_LOG2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .wb           (bus),
    .lab_dat_i    (lab_dat),
    .lab_wr_i     (lab_wr),
    .fifo_empty_o (fifo_empty)
  );

  always #5 clk = ~clk;

  // Starts at a falling edge; ends at the falling edge after the ack cycle
  task automatic wb_xfer(input logic we, input logic [15:0] adr, input logic [31:0] wdat,
                         input logic [NUM_CH-1:0] swr, input logic [NUM_CH*16-1:0] sdat,
                         output logic [31:0] rdat, output logic ack_ok);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
    bus.wb_adr_i = adr;  bus.wb_dat_i = wdat;
    lab_wr = swr; lab_dat = sdat;
    @(posedge clk);
    @(negedge clk);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0; lab_wr = '0;
    ack_ok = (bus.wb_ack_o === 1'b0);
    @(negedge clk);
    ack_ok = ack_ok & (bus.wb_ack_o === 1'b1);
    rdat = bus.wb_dat_o;
    @(negedge clk);
    ack_ok = ack_ok & (bus.wb_ack_o === 1'b0);
  endtask

  task automatic wb_rd(input logic [15:0] adr, output logic [31:0] d, output logic ok);
    wb_xfer(1'b0, adr, 32'h0, '0, '0, d, ok);
  endtask

  task automatic wb_wr(input logic [15:0] adr, input logic [31:0] wdat, output logic ok);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, wdat, '0, '0, dummy, ok);
  endtask

  task automatic push_sample(input int ch, input logic [15:0] v);
    lab_dat = '0; lab_dat[16*ch +: 16] = v;
    lab_wr = '0;  lab_wr[ch] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lab_wr = '0;
  endtask

  function automatic logic [15:0] cnt_adr(input int ch);
    return 16'h8100 + 16'(4 * ch);
  endfunction

  function automatic logic [15:0] win_adr(input int ch);
    return 16'(ch << 10);
  endfunction

  task automatic test_reset();
    logic [31:0] d; logic ok;
    repeat (3) @(negedge clk);
    checks++; if (bus.wb_ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack_held got %b exp 0", bus.wb_ack_o); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.wb_ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", bus.wb_ack_o); end
    checks++; if (bus.wb_dat_o !== 32'h0) begin errors++; $display("FAIL rst_dat got %h exp 00000000", bus.wb_dat_o); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b exp 1", fifo_empty); end
    wb_rd(16'h8004, d, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rst_rd_ack got %b exp 1", ok); end
    checks++; if (d !== 32'h00FF_FFFF) begin errors++; $display("FAIL rst_empty_mask got %h exp 00ffffff", d); end
    wb_rd(16'h8008, d, ok);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_ovf got %h exp 00000000", d); end
    wb_rd(16'h800C, d, ok);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_unf got %h exp 00000000", d); end
    wb_rd(cnt_adr(0), d, ok);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_count0 got %h exp 00000000", d); end
  endtask

  task automatic test_pack_pop();
    logic [31:0] d; logic ok;
    push_sample(3, 16'h1111);
    push_sample(3, 16'h2222);
    wb_rd(cnt_adr(3), d, ok);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL pack_count_pre got %h exp 00000001", d); end
    checks++; if (fifo_empty !== 1'b0) begin errors++; $display("FAIL pack_empty_pre got %b exp 0", fifo_empty); end
    wb_rd(16'h0C00, d, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL pack_ack got %b exp 1", ok); end
    checks++; if (d !== 32'h2222_1111) begin errors++; $display("FAIL pack_data got %h exp 22221111", d); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL pack_empty_post got %b exp 1", fifo_empty); end
    wb_rd(cnt_adr(3), d, ok);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL pack_count_post got %h exp 00000000", d); end
  endtask

  task automatic test_overflow_drain();
    logic [31:0] d, exp; logic ok;
    for (int j = 0; j < 34; j++) push_sample(0, 16'(16'h0100 + j));
    wb_rd(cnt_adr(0), d, ok);
    checks++; if (d !== 32'd16) begin errors++; $display("FAIL ovf_count got %h exp 00000010", d); end
    wb_rd(16'h8008, d, ok);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL ovf_mask got %h exp 00000001", d); end
    for (int k = 0; k < 16; k++) begin
      exp = {16'(16'h0100 + 2*k + 1), 16'(16'h0100 + 2*k)};
      wb_rd(win_adr(0), d, ok);
      checks++; if (d !== exp || ok !== 1'b1) begin errors++; $display("FAIL ovf_drain[%0d] got %h ack %b exp %h", k, d, ok, exp); end
    end
    wb_rd(win_adr(0), d, ok);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL unf_data got %h exp 00000000", d); end
    wb_rd(16'h800C, d, ok);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL unf_mask got %h exp 00000001", d); end
  endtask

  task automatic test_bad_chan_and_clear();
    logic [31:0] d; logic ok;
    wb_rd(win_adr(30), d, ok);
    checks++; if (d !== 32'h0 || ok !== 1'b1) begin errors++; $display("FAIL ch30_data got %h ack %b exp 00000000", d, ok); end
    wb_rd(16'h800C, d, ok);
    checks++; if (d !== 32'h1) begin errors++; $display("FAIL ch30_unf got %h exp 00000001", d); end
    wb_wr(16'h8004, 32'hFFFF_FFFF, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wr_ignored_ack got %b exp 1", ok); end
    wb_wr(16'h8000, 32'h2, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL clr_ack got %b exp 1", ok); end
    wb_rd(16'h8008, d, ok);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL clr_ovf got %h exp 00000000", d); end
    wb_rd(16'h800C, d, ok);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL clr_unf got %h exp 00000000", d); end
    wb_rd(16'h8000, d, ok);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL ctrl_read got %h exp 00000000", d); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d, exp; logic ok;
    logic [NUM_CH-1:0] swr; logic [NUM_CH*16-1:0] sdat;
    for (int j = 0; j < 32; j++) push_sample(5, 16'(16'h5000 + j));
    push_sample(5, 16'h5020);
    swr = '0; swr[5] = 1'b1; sdat = '0; sdat[16*5 +: 16] = 16'h5021;
    wb_xfer(1'b0, win_adr(5), 32'h0, swr, sdat, d, ok);
    checks++; if (d !== 32'h5001_5000) begin errors++; $display("FAIL fpp_pop got %h exp 50015000", d); end
    wb_rd(cnt_adr(5), d, ok);
    checks++; if (d !== 32'd16) begin errors++; $display("FAIL fpp_count got %h exp 00000010", d); end
    wb_rd(16'h8008, d, ok);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL fpp_ovf got %h exp 00000000", d); end
    for (int k = 1; k <= 16; k++) begin
      exp = {16'(16'h5000 + 2*k + 1), 16'(16'h5000 + 2*k)};
      wb_rd(win_adr(5), d, ok);
      checks++; if (d !== exp) begin errors++; $display("FAIL fpp_drain[%0d] got %h exp %h", k, d, exp); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] d; logic ok;
    logic [NUM_CH-1:0] swr; logic [NUM_CH*16-1:0] sdat;
    push_sample(7, 16'h1234);
    push_sample(2, 16'h0001);
    push_sample(2, 16'h0002);
    swr = '0; swr[7] = 1'b1; sdat = '0; sdat[16*7 +: 16] = 16'h9999;
    wb_xfer(1'b1, 16'h8000, 32'h1, swr, sdat, d, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL flush_ack got %b exp 1", ok); end
    wb_rd(cnt_adr(2), d, ok);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL flush_count2 got %h exp 00000000", d); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL flush_empty got %b exp 1", fifo_empty); end
    push_sample(7, 16'hAAAA);
    push_sample(7, 16'hBBBB);
    wb_rd(win_adr(7), d, ok);
    checks++; if (d !== 32'hBBBB_AAAA) begin errors++; $display("FAIL flush_repack got %h exp bbbbaaaa", d); end
  endtask

  task automatic test_pop_empty_push();
    logic [31:0] d; logic ok;
    logic [NUM_CH-1:0] swr; logic [NUM_CH*16-1:0] sdat;
    push_sample(9, 16'h0001);
    swr = '0; swr[9] = 1'b1; sdat = '0; sdat[16*9 +: 16] = 16'h0002;
    wb_xfer(1'b0, win_adr(9), 32'h0, swr, sdat, d, ok);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL pep_data got %h exp 00000000", d); end
    wb_rd(16'h800C, d, ok);
    checks++; if (d !== 32'h0000_0200) begin errors++; $display("FAIL pep_unf got %h exp 00000200", d); end
    wb_rd(cnt_adr(9), d, ok);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL pep_count got %h exp 00000001", d); end
    wb_rd(win_adr(9), d, ok);
    checks++; if (d !== 32'h0002_0001) begin errors++; $display("FAIL pep_retained got %h exp 00020001", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic ok;
    push_sample(4, 16'hBEEF);
    push_sample(4, 16'hCAFE);
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = win_adr(4);
    @(posedge clk);
    @(negedge clk);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (bus.wb_ack_o !== 1'b0) begin errors++; $display("FAIL rmid_ack got %b exp 0", bus.wb_ack_o); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.wb_ack_o !== 1'b0) begin errors++; $display("FAIL rmid_ack_late got %b exp 0", bus.wb_ack_o); end
    checks++; if (bus.wb_dat_o !== 32'h0) begin errors++; $display("FAIL rmid_dat got %h exp 00000000", bus.wb_dat_o); end
    checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL rmid_empty got %b exp 1", fifo_empty); end
    wb_rd(16'h800C, d, ok);
    checks++; if (d !== 32'h0 || ok !== 1'b1) begin errors++; $display("FAIL rmid_unf got %h ack %b exp 00000000", d, ok); end
    wb_rd(cnt_adr(4), d, ok);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rmid_count got %h exp 00000000", d); end
    push_sample(4, 16'h0003);
    push_sample(4, 16'h0004);
    wb_rd(win_adr(4), d, ok);
    checks++; if (d !== 32'h0004_0003 || ok !== 1'b1) begin errors++; $display("FAIL rmid_after got %h ack %b exp 00040003", d, ok); end
  endtask

  initial begin
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = '0;   bus.wb_dat_i = '0;   bus.wb_sel_i = 4'hF;
    test_reset();
    test_pack_pop();
    test_overflow_drain();
    test_bad_chan_and_clear();
    test_full_push_pop();
    test_flush();
    test_pop_empty_push();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lab4d_wb_sample_fifo.md
# lab4d_wb_sample_fifo

Single-clock, parametrised multi-channel sample buffer between the LAB4D digitiser readout and the Wishbone slave bus. Packs 16-bit samples from each channel into 32-bit words, queues them in a per-channel inferred-RAM FIFO, and drains them through a streaming data window. Adds what the previous generation lacked: configurable depth and channel count, occupancy counters, sticky overflow/underflow flags, and software flush through a register page.

## Interface
Parameters:
- NUM_CH, 24, number of LAB4D channels (1..32)
- DATA_BITS, 16, sample width; fixed at 16 (two samples per 32-bit word)
- DEPTH_LOG2, 10, log2 of FIFO depth in 32-bit words per channel
- L4W, $clog2(NUM_CH), channel-select width (derived, not overridden)

Ports:
- clk_i  in  1  single clock for bus and sample side
- rst_i  in  1  reset; synchronous, active-high
- wb_cyc_i  in  1  Wishbone cycle
- wb_stb_i  in  1  Wishbone strobe
- wb_we_i  in  1  write enable
- wb_adr_i  in  16  byte address
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte selects (ignored; full-word access only)
- wb_ack_o  out  1  acknowledge
- wb_err_o  out  1  tied 0
- wb_rty_o  out  1  tied 0
- wb_dat_o  out  32  read data
- lab_dat_i  in  NUM_CH*16  channel i sample at [16*i +: 16]
- lab_wr_i  in  NUM_CH  per-channel sample strobe
- fifo_empty_o  out  1  AND of all channel empty flags

## Operation
- Packing: per channel, first strobed sample latched into low half; second completes word {s1,s0} and pushes it. Odd trailing sample stays latched until partner arrives.
- Push to full channel (count == 2^DEPTH_LOG2) with no same-cycle pop: word dropped, OVF[ch] set. Push with same-cycle pop on a full channel: accepted, count unchanged.
- Address map: adr[15]=0 data window, channel = adr[14 -: L4W]; remaining bits ignored (streaming pop). adr[15]=1 register page, index adr[9:2].
- Data-window read: pops one word from selected channel. Empty channel: returns 0x00000000, no pop, UNF[ch] set. Channel index >= NUM_CH: returns 0, no side effects.
- Registers: 0x8000 CTRL (W bit0 = flush all, bit1 = clear OVF/UNF; reads 0); 0x8004 EMPTY mask; 0x8008 OVF mask; 0x800C UNF mask; 0x8100+4*ch count of channel ch, zero-extended (DEPTH_LOG2+1 bits); unmapped reads 0.
- Writes outside CTRL acked and ignored.
- Flush: clears all pointers, counts, half-word latches; a sample strobed in the flush cycle is discarded. Sticky flags unaffected.
- FSM: IDLE -> READ on cyc&stb (pop/flag update happen in that cycle); READ -> ACK (RAM/register output registered); ACK -> IDLE unconditionally. Writes also traverse READ and ACK.

## Timing
- Request accepted at cycle N (state IDLE) -> wb_ack_o high at N+2 for exactly one cycle, wb_dat_o valid during ack; next request accepted no earlier than N+3.
- Sample pushed at cycle N: count and EMPTY visible to a register read accepted at N+1; data readable by a pop accepted at N+1.
- Push and pop same channel same cycle: count unchanged. Pop from empty with same-cycle push: underflow, pushed word retained.
- Pointers wrap modulo 2^DEPTH_LOG2; count saturates by the full rule, never wraps.
- Reset: state IDLE, wb_ack_o 0, wb_dat_o 0, all counts 0, latches empty, OVF/UNF 0, fifo_empty_o 1 (first cycle after reset). Reset mid-transaction aborts it, no ack issued.
- fifo_empty_o is combinational from counts; one cycle after the last pop it reads 1.

## Structure
- Package lab4d_fifo_pkg: FSM state enum (IDLE, READ, ACK), register offsets (CTRL, EMPTY, OVF, UNF, COUNT base), CTRL bit positions.
- Sub-module lab4d_chan_fifo: one channel's packer, simple dual-port inferred RAM (registered read), write/read pointers, count, full/empty; instantiated NUM_CH times in a generate loop.
- Top holds FSM, address decode, sticky flags, output mux register.

## Test plan
- Strobe ch3 with 0x1111, 0x2222, then read 0x0C00 -> ack at +2 cycles, data 0x22221111; count[3] 1 -> 0; fifo_empty_o returns to 1.
- DEPTH_LOG2=4: push 17 words to ch0 -> count 16, OVF bit0 set; drain 16 reads in order, 17th read returns 0 and sets UNF bit0.
- Full ch5 with simultaneous push and pop -> count stays 16, no OVF; popped and pushed words both correct in sequence.
- Strobe one sample on ch7, write CTRL=1 -> count 0, latch cleared; next two samples 0xAAAA, 0xBBBB read back 0xBBBBAAAA.
- Write CTRL=2 after forced OVF/UNF -> masks read 0; read channel 30 with NUM_CH=24 -> data 0, no flag change.
- Assert rst_i between accept and ack -> no ack, all registers at reset values, subsequent read completes normally.
